// File: rtl/mips_pkg.sv
// Shared decode definitions for the execute-stage units.
package mips_pkg;

  localparam int DATA_WIDTH = 32;

  // Decoded ALU operation codes seen by the HI/LO unit.
  typedef enum logic [4:0] {
    CONTROL_MULT  = 5'b10000,
    CONTROL_MULTU = 5'b10001,
    CONTROL_DIV   = 5'b10010,
    CONTROL_DIVU  = 5'b10011,
    CONTROL_MTLO  = 5'b10101,
    CONTROL_MTHI  = 5'b10110
  } alu_control_t;

  // True for the two signed operations that need sign handling.
  function automatic logic is_signed_op(input logic [4:0] ctl);
    return (ctl == CONTROL_MULT) || (ctl == CONTROL_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Issue/result bundle between decode/control and the HI/LO unit.
// Handshake: an op is taken on a rising clk edge where start is high, busy is
// low and at least one write enable is set; while busy is high start and all
// decoder inputs are don't-care. done is a one-cycle pulse meaning hi/lo were
// just updated (done and a new start may coincide).
interface hilo_muldiv_unit_if
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH
) ();
  logic                  start;
  logic [4:0]            alu_control;
  logic                  LO_write_enable;
  logic                  HI_write_enable;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output start, alu_control, LO_write_enable, HI_write_enable, op_a, op_b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, alu_control, LO_write_enable, HI_write_enable, op_a, op_b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_unit_div_iter.sv
// Restoring unsigned divider core: load operands, then one quotient bit per step.
module div_iter
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  logic [DATA_WIDTH-1:0] quot_q, quot_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] dsr_q, dsr_d;
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   diff;

  // Shift next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    shifted = {rem_q, quot_q[DATA_WIDTH-1]};
    diff    = shifted - {1'b0, dsr_q};
    quot_d  = quot_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    if (load) begin
      quot_d = dividend;
      rem_d  = '0;
      dsr_d  = divisor;
    end else if (step) begin
      if (diff[DATA_WIDTH]) begin
        rem_d  = shifted[DATA_WIDTH-1:0];
        quot_d = {quot_q[DATA_WIDTH-2:0], 1'b0};
      end else begin
        rem_d  = diff[DATA_WIDTH-1:0];
        quot_d = {quot_q[DATA_WIDTH-2:0], 1'b1};
      end
    end
  end

  // Divider working registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quot_q <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO unit: single-cycle multiply and MTHI/MTLO, iterative divide, HI/LO regs.
module hilo_muldiv_unit
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  hilo_muldiv_unit_if.slave  bus,
  output logic [1:0]         dbg_state
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  neg_quot_q, neg_quot_d;  // signs of operands differ
  logic                  neg_rem_q, neg_rem_d;    // dividend was negative
  logic                  div_zero_q, div_zero_d;
  logic                  wr_hi_q, wr_hi_d;        // enables captured at issue
  logic                  wr_lo_q, wr_lo_d;

  logic                  accept;
  logic                  sgn;
  logic                  sign_a, sign_b;
  logic [DATA_WIDTH-1:0] abs_a, abs_b;
  logic [2*DATA_WIDTH-1:0] ext_a, ext_b, product;
  logic                  div_load, div_step;
  logic [DATA_WIDTH-1:0] quotient, remainder;

  div_iter #(.DATA_WIDTH(DATA_WIDTH)) u_div_iter (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (div_load),
    .step      (div_step),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Operand conditioning shared by multiply (sign extension) and divide (magnitude).
  always_comb begin
    sgn     = is_signed_op(bus.alu_control);
    sign_a  = sgn & bus.op_a[DATA_WIDTH-1];
    sign_b  = sgn & bus.op_b[DATA_WIDTH-1];
    abs_a   = sign_a ? (~bus.op_a + DATA_WIDTH'(1)) : bus.op_a;
    abs_b   = sign_b ? (~bus.op_b + DATA_WIDTH'(1)) : bus.op_b;
    ext_a   = {{DATA_WIDTH{sign_a}}, bus.op_a};
    ext_b   = {{DATA_WIDTH{sign_b}}, bus.op_b};
    product = ext_a * ext_b;
  end

  // Issue decode, divide sequencing and HI/LO next values.
  always_comb begin
    accept     = bus.start && !busy_q && (bus.LO_write_enable || bus.HI_write_enable);
    state_d    = state_q;
    count_d    = count_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    wr_hi_d    = wr_hi_q;
    wr_lo_d    = wr_lo_q;
    div_load   = 1'b0;
    div_step   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.alu_control)
            CONTROL_MULT, CONTROL_MULTU: begin
              if (bus.HI_write_enable) hi_d = product[2*DATA_WIDTH-1:DATA_WIDTH];
              if (bus.LO_write_enable) lo_d = product[DATA_WIDTH-1:0];
              done_d = 1'b1;
            end
            CONTROL_DIV, CONTROL_DIVU: begin
              div_load   = 1'b1;
              neg_quot_d = sign_a ^ sign_b;
              neg_rem_d  = sign_a;
              div_zero_d = (bus.op_b == '0);
              wr_hi_d    = bus.HI_write_enable;
              wr_lo_d    = bus.LO_write_enable;
              count_d    = '0;
              busy_d     = 1'b1;
              state_d    = RUN;
            end
            CONTROL_MTHI: begin
              if (bus.HI_write_enable) hi_d = bus.op_a;
              done_d = 1'b1;
            end
            CONTROL_MTLO: begin
              if (bus.LO_write_enable) lo_d = bus.op_a;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        div_step = 1'b1;
        if (count_q == CNT_W'(DATA_WIDTH - 1)) begin
          count_d = '0;
          state_d = FIX;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      FIX: begin
        if (!div_zero_q) begin
          if (wr_lo_q) lo_d = neg_quot_q ? (~quotient + DATA_WIDTH'(1)) : quotient;
          if (wr_hi_q) hi_d = neg_rem_q ? (~remainder + DATA_WIDTH'(1)) : remainder;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, HI/LO and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      wr_hi_q    <= 1'b0;
      wr_lo_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      wr_hi_q    <= wr_hi_d;
      wr_lo_q    <= wr_lo_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign dbg_state = state_q;

endmodule
